// File: rtl/stoch_pkg.sv
// -----------------------------------------------------------------------------
// stoch_pkg
// Shared types and helpers for the saturating stochastic add/sub array.
//   op_mode_e     : per-array operation select (OP_ADD / OP_SUB)
//   clamp_residue : clamps a signed residue into 0 .. cmax
// -----------------------------------------------------------------------------
package stoch_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_mode_e;

   // Residue outside the counter range is discarded, never wrapped.
   function automatic int clamp_residue(input int r, input int cmax);
      if (r < 0) begin
         return 0;
      end
      if (r > cmax) begin
         return cmax;
      end
      return r;
   endfunction

endpackage

// File: rtl/stoch_sat_addsub.sv
// -----------------------------------------------------------------------------
// stoch_sat_addsub
// Scalar element: one saturating stochastic add/sub with a CNT_W-bit residue
// counter. The matrix level supplies the shared mode and mode-change strobe.
// Optional feature macro: STOCH_SAT_FLAG_EN (adds the residue-clamp flag).
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   en_i, clr_i  : advance / synchronous clear
//   mode_i       : current operation
//   mode_chg_i   : mode differs from the last registered mode (flush residue)
//   a_i, b_i     : operand bits
//   y_o          : registered result bit
//   sat_o        : registered clamp flag (STOCH_SAT_FLAG_EN only)
// -----------------------------------------------------------------------------
module stoch_sat_addsub
   import stoch_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     en_i,
   input  logic     clr_i,
   input  op_mode_e mode_i,
   input  logic     mode_chg_i,
   input  logic     a_i,
   input  logic     b_i,
`ifdef STOCH_SAT_FLAG_EN
   output logic     sat_o,
`endif
   output logic     y_o
);

   localparam int SW   = CNT_W + 2;
   localparam int CMAX = 2**CNT_W - 1;

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 y_q, y_d;
   logic signed [SW-1:0] a_term, b_term, c_eff, s, r;
   logic                 clamp_d;

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      a_term = '0;
      b_term = '0;
      a_term[0] = a_i;
      if (b_i) begin
         // '1 in a signed vector is -1
         b_term = (mode_i == OP_SUB) ? '1 : SW'(1);
      end
      c_eff   = mode_chg_i ? '0 : $signed({2'b00, cnt_q});
      s       = a_term + b_term + c_eff;
      y_d     = (s >= 1);
      r       = s - $signed({{(SW-1){1'b0}}, y_d});
      cnt_d   = CNT_W'(clamp_residue(int'(r), CMAX));
      clamp_d = (r < 0) || (r > CMAX);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         y_q   <= 1'b0;
      end else if (clr_i) begin
         cnt_q <= '0;
         y_q   <= 1'b0;
      end else if (en_i) begin
         cnt_q <= cnt_d;
         y_q   <= y_d;
      end else begin
         // stalled cycles emit 0 while the residue is held
         y_q   <= 1'b0;
      end
   end

   assign y_o = y_q;

`ifdef STOCH_SAT_FLAG_EN
   logic sat_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sat_q <= 1'b0;
      end else if (clr_i || !en_i) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= clamp_d;
      end
   end

   assign sat_o = sat_q;
`else
   // clamp detect has no consumer in this build
   logic unused_clamp;
   assign unused_clamp = clamp_d;
`endif

endmodule

// File: rtl/stoch_sat_addsub_mat.sv
// -----------------------------------------------------------------------------
// stoch_sat_addsub_mat
// Element-wise saturating stochastic add/subtract over a NUM_ROWS x NUM_COLS
// matrix of bitstreams: y = min(1, a+b) (OP_ADD) or max(0, a-b) (OP_SUB).
// Optional feature macro: STOCH_SAT_FLAG_EN (adds the SAT output).
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   EN   : advance streams, low = stall (Y emits 0)
//   CLR  : synchronous clear of counters, Y, SAT; captures MODE
//   MODE : 0 = OP_ADD, 1 = OP_SUB, shared by all elements
//   A, B : operand bitstreams
//   Y    : registered result bitstreams
//   SAT  : registered residue-clamp flags (STOCH_SAT_FLAG_EN only)
// -----------------------------------------------------------------------------
module stoch_sat_addsub_mat
   import stoch_pkg::*;
#(
   parameter int NUM_ROWS = 2,
   parameter int NUM_COLS = 2,
   parameter int CNT_W    = 2
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             EN,
   input  logic                             CLR,
   input  logic                             MODE,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] A,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] B,
`ifdef STOCH_SAT_FLAG_EN
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0] SAT,
`endif
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0] Y
);

   op_mode_e mode_in;
   op_mode_e mode_q;
   logic     mode_chg;

   assign mode_in  = op_mode_e'(MODE);
   // a mode change flushes residue in the same cycle it is seen
   assign mode_chg = (mode_in != mode_q);

   // mode toggles during a stall are only registered on the next EN or CLR edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q <= OP_ADD;
      end else if (CLR || EN) begin
         mode_q <= mode_in;
      end
   end

   for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
         stoch_sat_addsub #(
            .CNT_W (CNT_W)
         ) u_elem (
            .clk_i      (CLK),
            .rst_i      (RST),
            .en_i       (EN),
            .clr_i      (CLR),
            .mode_i     (mode_in),
            .mode_chg_i (mode_chg),
            .a_i        (A[gr][gc]),
            .b_i        (B[gr][gc]),
`ifdef STOCH_SAT_FLAG_EN
            .sat_o      (SAT[gr][gc]),
`endif
            .y_o        (Y[gr][gc])
         );
      end
   end

endmodule

// File: tb/tb_stoch_sat_addsub_mat.sv
// -----------------------------------------------------------------------------
// tb_stoch_sat_addsub_mat
// Directed, table-driven bench for the 2x2, CNT_W=2 matrix. Each table row is
// one clock cycle of stimulus plus the Y (and SAT) expected right after it.
// Reset and mode-flush corners are written out by hand.
// -----------------------------------------------------------------------------
module tb_stoch_sat_addsub_mat;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   typedef struct packed {
      logic       en;
      logic       clr;
      logic       mode;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] y;
      logic [3:0] sat;
   } vec_t;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            EN  = 1'b0;
   logic            CLR = 1'b0;
   logic            MODE = 1'b0;
   logic [1:0][1:0] A = '0;
   logic [1:0][1:0] B = '0;
   logic [1:0][1:0] Y;
`ifdef STOCH_SAT_FLAG_EN
   logic [1:0][1:0] SAT;
`endif

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   stoch_sat_addsub_mat #(
      .NUM_ROWS (2),
      .NUM_COLS (2),
      .CNT_W    (2)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .CLR  (CLR),
      .MODE (MODE),
      .A    (A),
      .B    (B),
`ifdef STOCH_SAT_FLAG_EN
      .SAT  (SAT),
`endif
      .Y    (Y)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // drive one cycle of stimulus, then sample just after the rising edge
   task automatic step(input logic en, input logic clr, input logic mode,
                       input logic [3:0] a, input logic [3:0] b);
      EN   = en;
      CLR  = clr;
      MODE = mode;
      A    = a;
      B    = b;
      @(posedge CLK);
      #1;
   endtask

   function automatic vec_t mk(input logic en, input logic clr, input logic mode,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] y, input logic [3:0] sat);
      vec_t v;
      v.en = en; v.clr = clr; v.mode = mode;
      v.a = a; v.b = b; v.y = y; v.sat = sat;
      return v;
   endfunction

   initial begin
      // ADD, A=B=1: c 1,2,3,3,3 with Y=1; clamp on the 4th and 5th cycles
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 0, ADD, 4'hF, 4'hF, 4'hF, (i >= 3) ? 4'hF : 4'h0));
      // drain three residue cycles, then 0
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1, 0, ADD, 4'h0, 4'h0, (i < 3) ? 4'hF : 4'h0, 4'h0));
      // SUB, A=1 B=0
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1, 0, SUB, 4'hF, 4'h0, 4'hF, 4'h0));
      // SUB, A=0 B=1 with c=0: y=0, negative residue clamped
      vecs.push_back(mk(1, 0, SUB, 4'h0, 4'hF, 4'h0, 4'hF));
      // SUB, mixed per element: 1-1, 0-1, 1-0, 0-0
      vecs.push_back(mk(1, 0, SUB, 4'b0101, 4'b0011, 4'b0100, 4'b0010));
      // ADD, load c=2
      vecs.push_back(mk(1, 0, ADD, 4'hF, 4'hF, 4'hF, 4'h0));
      vecs.push_back(mk(1, 0, ADD, 4'hF, 4'hF, 4'hF, 4'h0));
      // stall 3 cycles with MODE toggled to SUB: Y=0, c and mode_q held
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, SUB, 4'hF, 4'hF, 4'h0, 4'h0));
      // resume ADD, A=B=0: the held c=2 drains 1,1,0
      vecs.push_back(mk(1, 0, ADD, 4'h0, 4'h0, 4'hF, 4'h0));
      vecs.push_back(mk(1, 0, ADD, 4'h0, 4'h0, 4'hF, 4'h0));
      vecs.push_back(mk(1, 0, ADD, 4'h0, 4'h0, 4'h0, 4'h0));
      // reload c=2, then CLR with EN=1 wipes it
      vecs.push_back(mk(1, 0, ADD, 4'hF, 4'hF, 4'hF, 4'h0));
      vecs.push_back(mk(1, 0, ADD, 4'hF, 4'hF, 4'hF, 4'h0));
      vecs.push_back(mk(1, 1, ADD, 4'hF, 4'hF, 4'h0, 4'h0));
      vecs.push_back(mk(1, 0, ADD, 4'h0, 4'h0, 4'h0, 4'h0));

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      check("reset_y", Y, 4'h0);
`ifdef STOCH_SAT_FLAG_EN
      check("reset_sat", SAT, 4'h0);
`endif
      @(negedge CLK);
      RST = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].a, vecs[i].b);
         check($sformatf("vec%0d_y", i), Y, vecs[i].y);
`ifdef STOCH_SAT_FLAG_EN
         check($sformatf("vec%0d_sat", i), SAT, vecs[i].sat);
`endif
      end

      // saturate c=3 in ADD, then switch to SUB with A=B=0: flushed, all zeros
      for (int i = 0; i < 4; i++) begin
         step(1, 0, ADD, 4'hF, 4'hF);
         check($sformatf("sat_load%0d_y", i), Y, 4'hF);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, SUB, 4'h0, 4'h0);
         check($sformatf("mode_flush%0d_y", i), Y, 4'h0);
      end

      // saturate again, then assert RST between edges
      step(1, 0, ADD, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, ADD, 4'hF, 4'hF);
         check($sformatf("rst_load%0d_y", i), Y, 4'hF);
      end
      RST = 1'b1;
      #1;
      check("rst_async_y", Y, 4'h0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(1, 0, ADD, 4'h0, 4'h0);
         check($sformatf("rst_residue%0d_y", i), Y, 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
